// File: rtl/dm9000a_pkg.sv
// Shared types and constants for the DM9000A host-bus scheduler.
package dm9000a_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned TMR_W  = 8;

   localparam int unsigned REQ_CFG = 0;
   localparam int unsigned REQ_PKT = 1;

   localparam logic [ADDR_W-1:0] REG_NCR   = 8'h00;
   localparam logic [ADDR_W-1:0] REG_NSR   = 8'h01;
   localparam logic [ADDR_W-1:0] REG_VIDL  = 8'h28;
   localparam logic [ADDR_W-1:0] REG_ISR   = 8'hFE;
   localparam logic [ADDR_W-1:0] REG_MRCMD = 8'hF2;
   localparam logic [ADDR_W-1:0] REG_MWCMD = 8'hF8;

   typedef enum logic [8:0] {
      ST_IDLE       = 9'h001,
      ST_IDX_SETUP  = 9'h002,
      ST_IDX_STROBE = 9'h004,
      ST_IDX_HOLD   = 9'h008,
      ST_GAP        = 9'h010,
      ST_DAT_SETUP  = 9'h020,
      ST_DAT_STROBE = 9'h040,
      ST_DAT_HOLD   = 9'h080,
      ST_DONE       = 9'h100
   } state_e;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } xact_t;

   // Index cycle places the register number on the low byte of SD.
   function automatic logic [DATA_W-1:0] idx_word(input logic [ADDR_W-1:0] a);
      return {8'h00, a};
   endfunction

endpackage

// File: rtl/dm9000a_bus_sched_if.sv
// Requester handshake and DM9000A pad bundle for the bus scheduler.
interface dm9000a_bus_sched_if #(
   parameter int unsigned CNT_W = 16
);
   logic [1:0]       iReq;
   logic             iWr0;
   logic             iWr1;
   logic [7:0]       iAddr0;
   logic [7:0]       iAddr1;
   logic [15:0]      iWdata0;
   logic [15:0]      iWdata1;
   logic [1:0]       oAck;
   logic [15:0]      oRdata;
   logic             oBusy;
   logic             oCs;
   logic             oCmd;
   logic             oIor;
   logic             oIow;
   logic             oSdOe;
   logic [15:0]      oSdOut;
   logic [15:0]      iSdIn;
   logic [CNT_W-1:0] oAccCnt0;
   logic [CNT_W-1:0] oAccCnt1;

   modport master (
      output iReq, iWr0, iWr1, iAddr0, iAddr1, iWdata0, iWdata1, iSdIn,
      input  oAck, oRdata, oBusy, oCs, oCmd, oIor, oIow, oSdOe, oSdOut,
             oAccCnt0, oAccCnt1
   );

   modport slave (
      input  iReq, iWr0, iWr1, iAddr0, iAddr1, iWdata0, iWdata1, iSdIn,
      output oAck, oRdata, oBusy, oCs, oCmd, oIor, oIow, oSdOe, oSdOut,
             oAccCnt0, oAccCnt1
   );
endinterface

// File: rtl/dm9000a_rr_arbiter.sv
// Two-way round-robin selector; last_q remembers who was served last.
module dm9000a_rr_arbiter (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       take_i,
   output logic       gnt_vld_c,
   output logic       gnt_idx_c
);

   logic last_q;

   // Reset value 1 makes requester 0 win the first contested grant.
   always_comb begin
      gnt_vld_c = |req_i;
      gnt_idx_c = (req_i == 2'b11) ? ~last_q : req_i[1];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else if (take_i && gnt_vld_c) begin
         last_q <= gnt_idx_c;
      end
   end

endmodule

// File: rtl/dm9000a_bus_sched.sv
// DM9000A host-bus scheduler: one index+data register transaction per grant.
// Optional completed-transaction counters are built when DM9000A_ACC_CNT_EN is defined.
module dm9000a_bus_sched
   import dm9000a_pkg::*;
#(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1,
   parameter int unsigned GAP_CYC    = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic               iDm9000aClk,
   input  logic               iRst,
   dm9000a_bus_sched_if.slave bus
);

   state_e             state_q, state_d;
   logic [TMR_W-1:0]   cnt_q, cnt_d;
   xact_t              xact_q, xact_d;
   logic               gnt_q, gnt_d;
   logic               take;
   logic               gnt_vld_c, gnt_idx_c;

   logic               cs_q, cs_d, cmd_q, cmd_d, ior_q, ior_d, iow_q, iow_d;
   logic               oe_q, oe_d, busy_q, busy_d;
   logic [DATA_W-1:0]  sdout_q, sdout_d, rdata_q, rdata_d, rdcap_q, rdcap_d;
   logic [1:0]         ack_q, ack_d;

   dm9000a_rr_arbiter u_arb (
      .clk_i     (iDm9000aClk),
      .rst_i     (iRst),
      .req_i     (bus.iReq),
      .take_i    (take),
      .gnt_vld_c (gnt_vld_c),
      .gnt_idx_c (gnt_idx_c)
   );

   // Down-counter value loaded on entry; the state exits when it reaches zero.
   function automatic logic [TMR_W-1:0] reload(input state_e s);
      case (s)
         ST_IDX_SETUP, ST_DAT_SETUP:   reload = TMR_W'(SETUP_CYC - 1);
         ST_IDX_STROBE, ST_DAT_STROBE: reload = TMR_W'(STROBE_CYC - 1);
         ST_IDX_HOLD, ST_DAT_HOLD:     reload = TMR_W'(HOLD_CYC - 1);
         ST_GAP:                       reload = TMR_W'(GAP_CYC - 1);
         default:                      reload = '0;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      xact_d  = xact_q;
      gnt_d   = gnt_q;
      take    = 1'b0;
      cs_d    = 1'b1;
      cmd_d   = 1'b1;
      ior_d   = 1'b1;
      iow_d   = 1'b1;
      oe_d    = 1'b0;
      sdout_d = '0;
      ack_d   = 2'b00;
      busy_d  = (state_q != ST_IDLE);
      rdata_d = rdata_q;
      rdcap_d = ior_q ? rdcap_q : bus.iSdIn;

      case (state_q)
         ST_IDLE: begin
            if (gnt_vld_c) begin
               take  = 1'b1;
               gnt_d = gnt_idx_c;
               if (gnt_idx_c == 1'(REQ_PKT)) begin
                  xact_d = '{wr: bus.iWr1, addr: bus.iAddr1, wdata: bus.iWdata1};
               end else begin
                  xact_d = '{wr: bus.iWr0, addr: bus.iAddr0, wdata: bus.iWdata0};
               end
               state_d = ST_IDX_SETUP;
            end
         end
         ST_IDX_SETUP:  if (cnt_q == '0) state_d = ST_IDX_STROBE;
         ST_IDX_STROBE: if (cnt_q == '0) state_d = ST_IDX_HOLD;
         ST_IDX_HOLD:   if (cnt_q == '0) state_d = ST_GAP;
         ST_GAP:        if (cnt_q == '0) state_d = ST_DAT_SETUP;
         ST_DAT_SETUP:  if (cnt_q == '0) state_d = ST_DAT_STROBE;
         ST_DAT_STROBE: if (cnt_q == '0) state_d = ST_DAT_HOLD;
         ST_DAT_HOLD:   if (cnt_q == '0) state_d = ST_DONE;
         ST_DONE:       state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase

      if (state_d != state_q) begin
         cnt_d = reload(state_d);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TMR_W'(1);
      end

      // Pad values decoded from the current state and registered one cycle later.
      case (state_q)
         ST_IDX_SETUP, ST_IDX_STROBE, ST_IDX_HOLD: begin
            cs_d    = 1'b0;
            cmd_d   = 1'b0;
            oe_d    = 1'b1;
            sdout_d = idx_word(xact_q.addr);
            iow_d   = (state_q != ST_IDX_STROBE);
         end
         ST_DAT_SETUP, ST_DAT_STROBE, ST_DAT_HOLD: begin
            cs_d = 1'b0;
            if (xact_q.wr) begin
               oe_d    = 1'b1;
               sdout_d = xact_q.wdata;
               iow_d   = (state_q != ST_DAT_STROBE);
            end else begin
               ior_d = (state_q != ST_DAT_STROBE);
            end
         end
         ST_DONE: begin
            ack_d[gnt_q] = 1'b1;
            if (!xact_q.wr) rdata_d = rdcap_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge iDm9000aClk) begin
      if (iRst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         xact_q  <= '0;
         gnt_q   <= 1'b0;
         cs_q    <= 1'b1;
         cmd_q   <= 1'b1;
         ior_q   <= 1'b1;
         iow_q   <= 1'b1;
         oe_q    <= 1'b0;
         sdout_q <= '0;
         ack_q   <= 2'b00;
         busy_q  <= 1'b0;
         rdata_q <= '0;
         rdcap_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         xact_q  <= xact_d;
         gnt_q   <= gnt_d;
         cs_q    <= cs_d;
         cmd_q   <= cmd_d;
         ior_q   <= ior_d;
         iow_q   <= iow_d;
         oe_q    <= oe_d;
         sdout_q <= sdout_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         rdata_q <= rdata_d;
         rdcap_q <= rdcap_d;
      end
   end

`ifdef DM9000A_ACC_CNT_EN
   logic [CNT_W-1:0] acc0_q, acc1_q;

   // Counted together with the ack, so an aborted transaction never counts.
   always_ff @(posedge iDm9000aClk) begin
      if (iRst) begin
         acc0_q <= '0;
         acc1_q <= '0;
      end else if (state_q == ST_DONE) begin
         if (gnt_q == 1'(REQ_CFG)) acc0_q <= acc0_q + CNT_W'(1);
         else                      acc1_q <= acc1_q + CNT_W'(1);
      end
   end

   assign bus.oAccCnt0 = acc0_q;
   assign bus.oAccCnt1 = acc1_q;
`else
   assign bus.oAccCnt0 = '0;
   assign bus.oAccCnt1 = '0;
`endif

   assign bus.oCs    = cs_q;
   assign bus.oCmd   = cmd_q;
   assign bus.oIor   = ior_q;
   assign bus.oIow   = iow_q;
   assign bus.oSdOe  = oe_q;
   assign bus.oSdOut = sdout_q;
   assign bus.oAck   = ack_q;
   assign bus.oBusy  = busy_q;
   assign bus.oRdata = rdata_q;

endmodule

// File: tb/tb_dm9000a_bus_sched.sv
// Scoreboard bench for dm9000a_bus_sched: default timing (u0) and stretched timing with CNT_W=2 (u1).
module tb_dm9000a_bus_sched;
   import dm9000a_pkg::*;

   localparam int LAT0 = 1 + 2 * (1 + 2 + 1) + 2;
   localparam int LAT1 = 1 + 2 * (1 + 4 + 1) + 3;
`ifdef DM9000A_ACC_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   typedef struct {
      logic [1:0]  ack;
      bit          chk_rd;
      logic [15:0] rd;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   exp_t q0[$];
   exp_t q1[$];

   logic        rst_v   [2];
   logic [1:0]  req_v   [2];
   logic        wr_v    [2][2];
   logic [7:0]  addr_v  [2][2];
   logic [15:0] wdata_v [2][2];
   logic [15:0] sdin_v  [2];

   logic [1:0]  ack_s [2];
   logic [15:0] rdata_s [2], sdout_s [2], c0_s [2], c1_s [2];
   logic        cs_s [2], cmd_s [2], ior_s [2], iow_s [2], oe_s [2], busy_s [2];

   dm9000a_bus_sched_if #(.CNT_W(16)) b0 ();
   dm9000a_bus_sched_if #(.CNT_W(2))  b1 ();

   dm9000a_bus_sched u0 (.iDm9000aClk(clk), .iRst(rst_v[0]), .bus(b0));
   dm9000a_bus_sched #(.STROBE_CYC(4), .GAP_CYC(3), .CNT_W(2))
      u1 (.iDm9000aClk(clk), .iRst(rst_v[1]), .bus(b1));

   assign b0.iReq = req_v[0];       assign b1.iReq = req_v[1];
   assign b0.iWr0 = wr_v[0][0];     assign b1.iWr0 = wr_v[1][0];
   assign b0.iWr1 = wr_v[0][1];     assign b1.iWr1 = wr_v[1][1];
   assign b0.iAddr0 = addr_v[0][0]; assign b1.iAddr0 = addr_v[1][0];
   assign b0.iAddr1 = addr_v[0][1]; assign b1.iAddr1 = addr_v[1][1];
   assign b0.iWdata0 = wdata_v[0][0]; assign b1.iWdata0 = wdata_v[1][0];
   assign b0.iWdata1 = wdata_v[0][1]; assign b1.iWdata1 = wdata_v[1][1];
   assign b0.iSdIn = sdin_v[0];     assign b1.iSdIn = sdin_v[1];

   assign ack_s[0] = b0.oAck;     assign ack_s[1] = b1.oAck;
   assign rdata_s[0] = b0.oRdata; assign rdata_s[1] = b1.oRdata;
   assign sdout_s[0] = b0.oSdOut; assign sdout_s[1] = b1.oSdOut;
   assign cs_s[0] = b0.oCs;       assign cs_s[1] = b1.oCs;
   assign cmd_s[0] = b0.oCmd;     assign cmd_s[1] = b1.oCmd;
   assign ior_s[0] = b0.oIor;     assign ior_s[1] = b1.oIor;
   assign iow_s[0] = b0.oIow;     assign iow_s[1] = b1.oIow;
   assign oe_s[0] = b0.oSdOe;     assign oe_s[1] = b1.oSdOe;
   assign busy_s[0] = b0.oBusy;   assign busy_s[1] = b1.oBusy;
   assign c0_s[0] = b0.oAccCnt0;  assign c0_s[1] = 16'(b1.oAccCnt0);
   assign c1_s[0] = b0.oAccCnt1;  assign c1_s[1] = 16'(b1.oAccCnt1);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Monitor: pops the scoreboard on every ack and checks pad invariants each cycle.
   logic rst_seen [2];
   logic cs_p [2], ior_p [2], iow_p [2];
   always @(posedge clk) begin
      rst_seen[0] <= rst_v[0];
      rst_seen[1] <= rst_v[1];
   end

   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (ack_s[d] != 2'b00) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
               check($sformatf("unexpected_ack_dut%0d", d), 32'(ack_s[d]), 32'd0);
            end else begin
               e = (d == 0) ? q0.pop_front() : q1.pop_front();
               check($sformatf("ack_value_dut%0d", d), 32'(ack_s[d]), 32'(e.ack));
               check($sformatf("ack_cycle_dut%0d", d), 32'(cyc), 32'(e.cyc));
               if (e.chk_rd) check($sformatf("rdata_dut%0d", d), 32'(rdata_s[d]), 32'(e.rd));
            end
         end
         check($sformatf("ior_iow_both_low_dut%0d", d), 32'(!ior_s[d] && !iow_s[d]), 32'd0);
         check($sformatf("oe_during_ior_dut%0d", d), 32'(!ior_s[d] && oe_s[d]), 32'd0);
         if (!rst_seen[d] && !cs_p[d] && cs_s[d])
            check($sformatf("cs_rise_after_strobe_dut%0d", d), 32'(ior_p[d] && iow_p[d]), 32'd1);
         cs_p[d] = cs_s[d];
         ior_p[d] = ior_s[d];
         iow_p[d] = iow_s[d];
      end
   end

   // Issues one transaction, pushes its expected ack, and tallies pad activity until the ack.
   task automatic txn(input int d, input int r, input logic wr, input logic [7:0] a,
                      input logic [15:0] wd, input logic [15:0] sd,
                      output int n_iow_idx, output int n_iow_dat, output int n_ior,
                      output int n_gap, output int n_busy, output int n_bad);
      exp_t e;
      bit   got, seen_lo;
      int   run;
      n_iow_idx = 0; n_iow_dat = 0; n_ior = 0; n_gap = 0; n_busy = 0; n_bad = 0;
      got = 1'b0; seen_lo = 1'b0; run = 0;
      @(negedge clk);
      wr_v[d][r] = wr; addr_v[d][r] = a; wdata_v[d][r] = wd; sdin_v[d] = sd;
      req_v[d][r] = 1'b1;
      e.ack = (r == 0) ? 2'b01 : 2'b10;
      e.chk_rd = !wr;
      e.rd = sd;
      e.cyc = cyc + 1 + ((d == 0) ? LAT0 : LAT1);
      push(d, e);
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         if (!iow_s[d] && !cmd_s[d]) begin
            n_iow_idx++;
            if (sdout_s[d] !== {8'h00, a} || !oe_s[d]) n_bad++;
         end
         if (!iow_s[d] && cmd_s[d]) begin
            n_iow_dat++;
            if (sdout_s[d] !== wd || !oe_s[d]) n_bad++;
         end
         if (!ior_s[d]) begin
            n_ior++;
            if (oe_s[d] || !cmd_s[d]) n_bad++;
         end
         if (!cs_s[d]) begin
            if (seen_lo) n_gap += run;
            run = 0;
            seen_lo = 1'b1;
         end else if (seen_lo) begin
            run++;
         end
         if (busy_s[d]) n_busy++;
         if (ack_s[d] != 2'b00) got = 1'b1;
      end
      req_v[d][r] = 1'b0;
      if (!got) check("txn_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int ni, nd, nr, ng, nb, nx, e0, r;
      bit got;
      for (int d = 0; d < 2; d++) begin
         rst_v[d] = 1'b1; req_v[d] = 2'b00; sdin_v[d] = 16'h0000;
         cs_p[d] = 1'b1; ior_p[d] = 1'b1; iow_p[d] = 1'b1;
         for (int r2 = 0; r2 < 2; r2++) begin
            wr_v[d][r2] = 1'b0; addr_v[d][r2] = 8'h00; wdata_v[d][r2] = 16'h0000;
         end
      end
      repeat (3) @(negedge clk);
      rst_v[0] = 1'b0; rst_v[1] = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_cs", 32'(cs_s[0]), 32'd1);
      check("rst_cmd", 32'(cmd_s[0]), 32'd1);
      check("rst_ior_iow", 32'({ior_s[0], iow_s[0]}), 32'b11);
      check("rst_oe", 32'(oe_s[0]), 32'd0);
      check("rst_sdout", 32'(sdout_s[0]), 32'd0);
      check("rst_ack_busy", 32'({ack_s[0], busy_s[0]}), 32'd0);
      check("rst_rdata", 32'(rdata_s[0]), 32'd0);
      check("rst_cnt", 32'({c0_s[0], c1_s[0]}), 32'd0);

      // T3: both requesting from reset, each re-raised after its ack
      wr_v[0][0] = 1'b1; addr_v[0][0] = REG_NCR;   wdata_v[0][0] = 16'h0001;
      wr_v[0][1] = 1'b1; addr_v[0][1] = REG_MWCMD; wdata_v[0][1] = 16'h1234;
      req_v[0] = 2'b11;
      e0 = cyc + 1;
      for (int k = 0; k < 4; k++)
         push(0, '{ack: (k % 2 == 0) ? 2'b01 : 2'b10, chk_rd: 1'b0, rd: 16'h0,
                   cyc: e0 + LAT0 + 12 * k});
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (ack_s[0] != 2'b00) got = 1'b1;
         end
         if (!got) begin
            check("t3_timeout", 32'd0, 32'd1);
         end else begin
            r = int'(ack_s[0][1]);
            req_v[0][r] = 1'b0;
            if (k < 3) begin
               @(negedge clk);
               req_v[0][r] = 1'b1;
            end
         end
      end
      req_v[0] = 2'b00;
      repeat (3) @(negedge clk);

      // T1: requester 0 reads VIDL
      txn(0, 0, 1'b0, REG_VIDL, 16'h0000, 16'h0A46, ni, nd, nr, ng, nb, nx);
      check("t1_iow_idx_cycles", 32'(ni), 32'd2);
      check("t1_iow_dat_cycles", 32'(nd), 32'd0);
      check("t1_ior_cycles", 32'(nr), 32'd2);
      check("t1_gap_cycles", 32'(ng), 32'd2);
      check("t1_busy_cycles", 32'(nb), 32'(LAT0));
      check("t1_pad_values", 32'(nx), 32'd0);
      repeat (2) @(negedge clk);

      // T2: requester 1 writes 0 to 8'h1F, then requester 0 writes MWCMD
      txn(0, 1, 1'b1, 8'h1F, 16'h0000, 16'hFFFF, ni, nd, nr, ng, nb, nx);
      check("t2_iow_idx_cycles", 32'(ni), 32'd2);
      check("t2_iow_dat_cycles", 32'(nd), 32'd2);
      check("t2_ior_cycles", 32'(nr), 32'd0);
      check("t2_pad_values", 32'(nx), 32'd0);
      check("t2_rdata_held", 32'(rdata_s[0]), 32'h0A46);
      txn(0, 0, 1'b1, REG_MWCMD, 16'hA55A, 16'h0000, ni, nd, nr, ng, nb, nx);
      check("t2b_iow_dat_cycles", 32'(nd), 32'd2);
      check("t2b_pad_values", 32'(nx), 32'd0);
      repeat (2) @(negedge clk);

      // T4: reset during the data strobe aborts without ack or count
      addr_v[0][0] = REG_ISR; wr_v[0][0] = 1'b0; sdin_v[0] = 16'h7777;
      req_v[0][0] = 1'b1;
      e0 = cyc + 1;
      for (int n = 0; n < 40 && cyc < e0 + 8; n++) @(negedge clk);
      check("t4_ior_low_before_rst", 32'(ior_s[0]), 32'd0);
      rst_v[0] = 1'b1;
      @(negedge clk);
      req_v[0][0] = 1'b0;
      rst_v[0] = 1'b0;
      check("t4_cs_ior_iow", 32'({cs_s[0], ior_s[0], iow_s[0]}), 32'b111);
      check("t4_oe", 32'(oe_s[0]), 32'd0);
      check("t4_ack_busy", 32'({ack_s[0], busy_s[0]}), 32'd0);
      repeat (20) @(negedge clk);
      check("t4_cnt0", 32'(c0_s[0]), CNT_ON ? 32'd4 : 32'd0);
      check("t4_cnt1", 32'(c1_s[0]), CNT_ON ? 32'd3 : 32'd0);

      // T5: stretched strobe and gap on u1
      txn(1, 0, 1'b0, REG_NSR, 16'h0000, 16'h5A5A, ni, nd, nr, ng, nb, nx);
      check("t5_iow_idx_cycles", 32'(ni), 32'd4);
      check("t5_ior_cycles", 32'(nr), 32'd4);
      check("t5_gap_cycles", 32'(ng), 32'd3);
      check("t5_busy_cycles", 32'(nb), 32'(LAT1));
      check("t5_pad_values", 32'(nx), 32'd0);

      // T6: four more requester-0 transactions wrap the 2-bit counter to 1
      for (int k = 0; k < 4; k++)
         txn(1, 0, 1'b1, REG_MWCMD, 16'(16'h1000 + k), 16'h0000, ni, nd, nr, ng, nb, nx);
      @(negedge clk);
      check("t6_cnt0_wrap", 32'(c0_s[1]), CNT_ON ? 32'd1 : 32'd0);
      check("t6_cnt1", 32'(c1_s[1]), 32'd0);

      repeat (5) @(negedge clk);
      check("scoreboard_drained_dut0", 32'(q0.size()), 32'd0);
      check("scoreboard_drained_dut1", 32'(q1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
